// File: rtl/popcount23_pkg.sv
// Shared types and constants for the 23-input ternary popcount neuron.
package popcount23_pkg;

    localparam int CHUNK_W = 23;
    localparam int PC_W    = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POS  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ACT_POS  = 2'b01;
    localparam logic [1:0] ACT_ZERO = 2'b00;
    localparam logic [1:0] ACT_NEG  = 2'b11;

    // Ternary activation with signed comparisons against both thresholds.
    function automatic logic [1:0] ternary_act(input int sum, input int thr_hi, input int thr_lo);
        if (sum > thr_hi)
            return ACT_POS;
        else if (sum < thr_lo)
            return ACT_NEG;
        else
            return ACT_ZERO;
    endfunction

endpackage

// File: rtl/popcount23_exact.sv
// Exact combinational population count of a 23-bit vector.
module popcount23_exact
    import popcount23_pkg::*;
(
    input  logic [CHUNK_W-1:0] input_a,
    output logic [PC_W-1:0]    count
);

    // NOTE: the default before the loop keeps every path assigned, so no latch is inferred.
    always_comb begin
        count = '0;
        for (int i = 0; i < CHUNK_W; i++)
            count = count + PC_W'(input_a[i]);
    end

endmodule

// File: rtl/popcount23_neuron_seq.sv
// Sequential ternary-weight neuron: time-shares one popcount unit between
// the +1 and -1 masks of each 23-bit chunk and accumulates a signed sum.
module popcount23_neuron_seq
    import popcount23_pkg::*;
#(
    parameter int MAX_CHUNKS = 8,
    parameter int ACC_W      = 10,
    parameter int THR_HI     = 0,
    parameter int THR_LO     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHUNK_W-1:0]      in_pos,
    input  logic [CHUNK_W-1:0]      in_neg,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [1:0]              out_act,
    output logic                    out_ovf
);

    localparam int CNT_W = $clog2(MAX_CHUNKS + 1);

    state_t                    state;
    logic [CHUNK_W-1:0]        pos_q;
    logic [CHUNK_W-1:0]        neg_q;
    logic                      last_q;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          chunk_cnt;

    logic [CHUNK_W-1:0]        pc_in;
    logic [PC_W-1:0]           pc_count;
    logic signed [ACC_W-1:0]   pc_ext;
    logic signed [ACC_W-1:0]   acc_after_neg;
    logic [CNT_W-1:0]          cnt_next;
    logic                      limit_hit;

    // Held low during reset so nothing is accepted while state is being cleared.
    assign in_ready = (state == IDLE) && !rst;

    always_comb begin
        pc_in = '0;
        case (state)
            POS:     pc_in = pos_q;
            NEG:     pc_in = neg_q;
            default: pc_in = '0;
        endcase
    end

    popcount23_exact u_popcount (
        .input_a (pc_in),
        .count   (pc_count)
    );

    assign pc_ext        = signed'({{(ACC_W - PC_W){1'b0}}, pc_count});
    assign acc_after_neg = acc - pc_ext;
    assign cnt_next      = chunk_cnt + 1'b1;
    assign limit_hit     = (cnt_next == CNT_W'(MAX_CHUNKS));

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            chunk_cnt <= '0;
            pos_q     <= '0;
            neg_q     <= '0;
            last_q    <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_act   <= ACT_ZERO;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        pos_q  <= in_pos;
                        neg_q  <= in_neg;
                        last_q <= in_last;
                        state  <= POS;
                    end
                end
                POS: begin
                    acc   <= acc + pc_ext;
                    state <= NEG;
                end
                NEG: begin
                    acc       <= acc_after_neg;
                    chunk_cnt <= cnt_next;
                    if (last_q || limit_hit) begin
                        // Reaching DONE without last_q can only mean the chunk limit fired.
                        out_valid <= 1'b1;
                        out_sum   <= acc_after_neg;
                        out_act   <= ternary_act(int'(acc_after_neg), THR_HI, THR_LO);
                        out_ovf   <= !last_q;
                        state     <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_ovf   <= 1'b0;
                        acc       <= '0;
                        chunk_cnt <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popcount23_neuron_seq.sv
// Directed self-checking bench for popcount23_neuron_seq (default and +/-5 thresholds).
module tb_popcount23_neuron_seq;

    localparam int ACC_W = 10;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_ready_t;
    logic [22:0]             in_pos;
    logic [22:0]             in_neg;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_valid_t;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic signed [ACC_W-1:0] out_sum_t;
    logic [1:0]              out_act;
    logic [1:0]              out_act_t;
    logic                    out_ovf;
    logic                    out_ovf_t;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    popcount23_neuron_seq #(.MAX_CHUNKS(8), .ACC_W(ACC_W), .THR_HI(0), .THR_LO(0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_act(out_act), .out_ovf(out_ovf)
    );

    popcount23_neuron_seq #(.MAX_CHUNKS(8), .ACC_W(ACC_W), .THR_HI(5), .THR_LO(-5)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
        .out_valid(out_valid_t), .out_ready(out_ready),
        .out_sum(out_sum_t), .out_act(out_act_t), .out_ovf(out_ovf_t)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_sum"},   out_sum,        0);
        check({tag, "_out_act"},   32'(out_act),   0);
        check({tag, "_out_ovf"},   32'(out_ovf),   0);
    endtask

    // Offers one chunk at a falling edge; returns one cycle after the handshake edge.
    task automatic send_chunk(input logic [22:0] p, input logic [22:0] n, input logic l);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 1);
        in_valid = 1'b1;
        in_pos   = p;
        in_neg   = n;
        in_last  = l;
        @(negedge clk);
        in_valid = 1'b0;
        in_pos   = '0;
        in_neg   = '0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int guard = 0;
        while (!out_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_valid_wait"}, 32'(out_valid), 1);
    endtask

    task automatic collect(input string tag, input int exp_sum, input logic [1:0] exp_act,
                           input logic exp_ovf, input logic [1:0] exp_act_t);
        wait_valid(tag);
        check({tag, "_sum"},      out_sum,          exp_sum);
        check({tag, "_act"},      32'(out_act),     32'(exp_act));
        check({tag, "_ovf"},      32'(out_ovf),     32'(exp_ovf));
        check({tag, "_sum_t"},    out_sum_t,        exp_sum);
        check({tag, "_act_t"},    32'(out_act_t),   32'(exp_act_t));
        check({tag, "_ready_lo"}, 32'(in_ready),    0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_clr"}, 32'(out_valid), 0);
        check({tag, "_ready_hi"},  32'(in_ready),  1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pos    = '0;
        in_neg    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;
        check("reset_release_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Single full-positive chunk with latency check
        send_chunk(23'h7FFFFF, 23'h0, 1'b1);
        @(negedge clk);
        check("lat_t2_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("lat_t3_valid", 32'(out_valid), 1);
        collect("single", 23, 2'b01, 1'b0, 2'b01);

        // Two chunks: 8 - 16 + 23 - 1 = 14
        send_chunk(23'h0000FF, 23'h00FFFF, 1'b0);
        repeat (2) @(negedge clk);
        check("two_mid_valid", 32'(out_valid), 0);
        send_chunk(23'h7FFFFF, 23'h000001, 1'b1);
        collect("two", 14, 2'b01, 1'b0, 2'b01);

        // Eight all-negative chunks, no last: forced exit at -184
        for (int i = 0; i < 8; i++)
            send_chunk(23'h0, 23'h7FFFFF, 1'b0);
        wait_valid("ovf");
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 1);
            check("hold_sum",   out_sum,        -184);
            check("hold_act",   32'(out_act),   32'(2'b11));
            check("hold_ovf",   32'(out_ovf),   1);
            check("hold_ready", 32'(in_ready),  0);
            @(negedge clk);
        end
        collect("ovf", -184, 2'b11, 1'b1, 2'b11);

        // Accumulator and overflow flag cleared after the forced exit
        send_chunk(23'h000001, 23'h0, 1'b1);
        collect("after_ovf", 1, 2'b01, 1'b0, 2'b00);

        // Reset pulsed during NEG of chunk 2
        send_chunk(23'h000003, 23'h0, 1'b0);
        send_chunk(23'h000007, 23'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        send_chunk(23'h000003, 23'h0, 1'b1);
        collect("post_rst", 2, 2'b01, 1'b0, 2'b00);

        // Threshold boundaries on the +/-5 instance
        send_chunk(23'h00001F, 23'h0, 1'b1);
        collect("thr_p5", 5, 2'b01, 1'b0, 2'b00);
        send_chunk(23'h00003F, 23'h0, 1'b1);
        collect("thr_p6", 6, 2'b01, 1'b0, 2'b01);
        send_chunk(23'h0, 23'h00001F, 1'b1);
        collect("thr_m5", -5, 2'b11, 1'b0, 2'b00);
        send_chunk(23'h0, 23'h00003F, 1'b1);
        collect("thr_m6", -6, 2'b11, 1'b0, 2'b11);

        // Zero sum with cancelling masks
        send_chunk(23'h000F0F, 23'h0F0F00, 1'b1);
        collect("zero", 0, 2'b00, 1'b0, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/popcount23_neuron_seq.md
POPCOUNT23_NEURON_SEQ -- requirements
Module: popcount23_neuron_seq

Interface
REQ-001 Parameter MAX_CHUNKS, default 8: maximum number of 23-bit chunks per neuron evaluation.
REQ-002 Parameter ACC_W, default 10: signed accumulator width; must satisfy 2^(ACC_W-1) > 23*MAX_CHUNKS.
REQ-003 Parameter THR_HI, default 0: signed upper activation threshold.
REQ-004 Parameter THR_LO, default 0: signed lower activation threshold; THR_LO <= THR_HI.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  chunk offered.
REQ-008 in_ready  output  1  chunk accepted when in_valid & in_ready.
REQ-009 in_pos  input  23  +1-weight activation mask for the chunk.
REQ-010 in_neg  input  23  -1-weight activation mask for the chunk.
REQ-011 in_last  input  1  final chunk of the current neuron.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  result consumed when out_valid & out_ready.
REQ-014 out_sum  output  ACC_W  signed sum of popcount(pos) minus popcount(neg) over all chunks.
REQ-015 out_act  output  2  ternary activation: 2'b01 = +1, 2'b00 = 0, 2'b11 = -1.
REQ-016 out_ovf  output  1  set when the chunk limit forced termination.

Function
REQ-017 FSM states: IDLE, POS, NEG, DONE.
REQ-018 in_ready = 1 only in IDLE; all other outputs are registered.
REQ-019 IDLE: on handshake, latch in_pos, in_neg and in_last, then go to POS.
REQ-020 POS: drive latched in_pos to the shared popcount unit, add its 5-bit result zero-extended into acc, then go to NEG.
REQ-021 NEG: drive latched in_neg to the same unit, subtract its result from acc, increment chunk_cnt.
REQ-022 NEG exit: go to DONE if latched in_last=1 or chunk_cnt reaches MAX_CHUNKS; otherwise return to IDLE.
REQ-023 Forced exit (limit reached with in_last=0) sets out_ovf=1; out_ovf is otherwise 0.
REQ-024 DONE: out_valid=1 and out_sum, out_act, out_ovf are held stable until out_ready=1.
REQ-025 On output handshake: clear acc, chunk_cnt and out_ovf, then go to IDLE.
REQ-026 out_act = +1 if sum > THR_HI; -1 if sum < THR_LO; else 0; all comparisons signed.
REQ-027 Latency: a single-chunk neuron accepted at cycle t asserts out_valid at cycle t+3.
REQ-028 Throughput: one chunk per 3 cycles; out_ready=1 in DONE returns to IDLE in 1 cycle.
REQ-029 The popcount unit is driven only in POS and NEG; its input is 0 otherwise.
REQ-030 Acc arithmetic is two's complement in ACC_W bits; REQ-002 guarantees no wrap.

Reset
REQ-031 rst=1 at any edge, including mid-neuron: state=IDLE, acc=0, chunk_cnt=0, out_valid=0, out_sum=0, out_act=2'b00, out_ovf=0.
REQ-032 in_ready is 0 while rst=1 and 1 in the first cycle after rst deasserts.

Structure
REQ-033 Package popcount23_pkg holds the state enum, ternary activation encodings (ACT_POS, ACT_ZERO, ACT_NEG) and the popcount width constant 5.
REQ-034 Exactly one sub-module instance: popcount23_exact (input_a[22:0] -> 5-bit count, combinational).
REQ-035 popcount23_exact is replaceable by any approximate popcount23 variant with an identical port list, without other changes.

Verification
REQ-036 Single chunk, pos=23'h7FFFFF, neg=0, last=1 -> out_valid at t+3, out_sum=23, out_act=2'b01, out_ovf=0.
REQ-037 Two chunks (pos=0x0000FF, neg=0x00FFFF), then (pos=0x7FFFFF, neg=0x000001) last -> out_sum=8-16+23-1=14, act=+1.
REQ-038 Eight chunks pos=0, neg=0x7FFFFF, in_last never set -> out_sum=-184, act=2'b11, out_ovf=1.
REQ-039 DONE with out_ready=0 for 5 cycles -> outputs stable and in_ready=0; then out_ready=1 -> IDLE next cycle and acc=0.
REQ-040 rst pulsed during NEG of chunk 2 -> all outputs at reset values; next neuron pos=0x3, last=1 -> out_sum=2, no residue from aborted neuron.
REQ-041 THR_HI=5, THR_LO=-5, sums 5, 6, -5, -6 -> act 0, +1, 0, -1.
